// File: rtl/tl_pkg.sv
// Shared TileLink crossbar definitions: arbiter state encoding, size constants
// and the beats-per-message helper.
package tl_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int TL_SIZE_1B   = 0;
    localparam int TL_SIZE_2B   = 1;
    localparam int TL_SIZE_4B   = 2;
    localparam int TL_SIZE_8B   = 3;
    localparam int TL_SIZE_16B  = 4;
    localparam int TL_SIZE_32B  = 5;
    localparam int TL_SIZE_64B  = 6;
    localparam int TL_SIZE_128B = 7;

    // Data-less messages are always a single beat regardless of their size field.
    function automatic logic [31:0] tl_num_beats(input logic [31:0] size,
                                                 input logic        has_data,
                                                 input int unsigned beat_log2);
        if (has_data && (size > 32'(beat_log2)))
            return 32'd1 << (size - 32'(beat_log2));
        else
            return 32'd1;
    endfunction

endpackage

// File: rtl/tl_rr_picker.sv
// Combinational round-robin picker: one-hot grant among req, searching from
// the index after last_winner and wrapping.
module tl_rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_winner,
    output logic [N-1:0]     pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_valid
);

    always_comb begin : pick_search
        int idx;
        idx        = 0;
        pick       = '0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_winner) + k) % N;
            if (!pick_valid && req[idx]) begin
                pick[idx]  = 1'b1;
                pick_idx   = IDX_W'(idx);
                pick_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl_burst_arbiter.sv
// Round-robin N:1 arbiter for a multi-beat TileLink channel; a grant is held
// until the winning message's final beat transfers.
module tl_burst_arbiter
    import tl_pkg::*;
#(
    parameter int N         = 4,
    parameter int DATA_W    = 100,
    parameter int SIZE_W    = 3,
    parameter int BEAT_LOG2 = 3,
    parameter int CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          valid_i,
    output logic [N-1:0]          ready_o,
    input  logic [N*DATA_W-1:0]   data_i,
    input  logic [N*SIZE_W-1:0]   size_i,
    input  logic [N-1:0]          has_data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_W-1:0]     data_o,
    output logic [N-1:0]          sel_o,
    output logic                  last_o,
    output logic                  busy_o
);

    localparam int IDX_W = $clog2(N);

    logic [DATA_W-1:0] data_arr [N];
    logic [SIZE_W-1:0] size_arr [N];
    logic [N-1:0]      lock_onehot;

    arb_state_t        state_reg, state_next;
    logic [IDX_W-1:0]  last_winner_reg, last_winner_next;
    logic [IDX_W-1:0]  lock_sel_reg, lock_sel_next;
    logic [CNT_W-1:0]  remaining_reg, remaining_next;

    logic [N-1:0]      pick;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic [31:0]       beats_full;
    logic [CNT_W-1:0]  beats_pick;
    logic              locked;
    logic              active;
    logic [IDX_W-1:0]  cur_idx;
    logic              fire;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            assign data_arr[gi]    = data_i[gi*DATA_W +: DATA_W];
            assign size_arr[gi]    = size_i[gi*SIZE_W +: SIZE_W];
            assign lock_onehot[gi] = (lock_sel_reg == IDX_W'(gi));
        end
    endgenerate

    tl_rr_picker #(.N(N), .IDX_W(IDX_W)) u_picker (
        .req         (valid_i),
        .last_winner (last_winner_reg),
        .pick        (pick),
        .pick_idx    (pick_idx),
        .pick_valid  (pick_valid)
    );

    assign beats_full = tl_num_beats(32'(size_arr[pick_idx]), has_data_i[pick_idx], BEAT_LOG2);
    assign beats_pick = beats_full[CNT_W-1:0];

    assign locked  = (state_reg == ARB_LOCKED);
    assign active  = locked | pick_valid;
    assign cur_idx = locked ? lock_sel_reg : pick_idx;

    // Outputs are forced quiet while reset is held, even though the picker keeps evaluating.
    assign sel_o   = rst_n ? (locked ? lock_onehot : pick) : '0;
    assign valid_o = rst_n & active & valid_i[cur_idx];
    assign ready_o = sel_o & {N{ready_i}};
    assign data_o  = (rst_n && active) ? data_arr[cur_idx] : '0;
    assign last_o  = rst_n & (locked ? (remaining_reg == CNT_W'(1))
                                     : (pick_valid && (beats_pick == CNT_W'(1))));
    assign busy_o  = rst_n & locked;
    assign fire    = valid_o & ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ARB_IDLE;
            last_winner_reg <= IDX_W'(N-1);
            lock_sel_reg    <= '0;
            remaining_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            last_winner_reg <= last_winner_next;
            lock_sel_reg    <= lock_sel_next;
            remaining_reg   <= remaining_next;
        end
    end

    // The rotation pointer only moves when a whole message has been accepted.
    always_comb begin
        state_next       = state_reg;
        last_winner_next = last_winner_reg;
        lock_sel_next    = lock_sel_reg;
        remaining_next   = remaining_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (fire) begin
                    if (beats_pick > CNT_W'(1)) begin
                        state_next     = ARB_LOCKED;
                        lock_sel_next  = pick_idx;
                        remaining_next = beats_pick - CNT_W'(1);
                    end else begin
                        last_winner_next = pick_idx;
                    end
                end
            end
            ARB_LOCKED: begin
                if (fire) begin
                    remaining_next = remaining_reg - CNT_W'(1);
                    if (remaining_reg == CNT_W'(1)) begin
                        state_next       = ARB_IDLE;
                        last_winner_next = lock_sel_reg;
                    end
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    a_beats_fit: assert property (@(posedge clk) disable iff (!rst_n)
        (!locked && fire) |-> ((beats_full >> CNT_W) == 32'd0));

endmodule

// File: tb/tb_tl_burst_arbiter.sv
// Randomised and directed checks of tl_burst_arbiter against a message-level
// reference model of round-robin grant and burst locking.
module tb_tl_burst_arbiter;

    localparam int N         = 4;
    localparam int DATA_W    = 100;
    localparam int SIZE_W    = 3;
    localparam int BEAT_LOG2 = 3;
    localparam int CNT_W     = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        valid_i;
    logic [N-1:0]        ready_o;
    logic [N*DATA_W-1:0] data_i;
    logic [N*SIZE_W-1:0] size_i;
    logic [N-1:0]        has_data_i;
    logic                valid_o;
    logic                ready_i;
    logic [DATA_W-1:0]   data_o;
    logic [N-1:0]        sel_o;
    logic                last_o;
    logic                busy_o;

    tl_burst_arbiter #(
        .N(N), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .BEAT_LOG2(BEAT_LOG2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .size_i(size_i), .has_data_i(has_data_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .sel_o(sel_o), .last_o(last_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Message-level model: which source owns the sink and how many beats it still owes.
    int  m_last;
    bit  m_locked;
    int  m_owner;
    int  m_rem;

    logic [N-1:0]      exp_sel, exp_ready;
    logic              exp_valid, exp_last, exp_busy;
    logic [DATA_W-1:0] exp_data;
    int                exp_owner, exp_beats;
    bit                exp_fire;

    function automatic int beats_of(int j);
        int sz;
        sz = int'(size_i[j*SIZE_W +: SIZE_W]);
        if (has_data_i[j] && sz > BEAT_LOG2) return 1 << (sz - BEAT_LOG2);
        return 1;
    endfunction

    task automatic model_reset();
        m_last   = N - 1;
        m_locked = 0;
        m_owner  = 0;
        m_rem    = 0;
    endtask

    task automatic model_eval();
        exp_sel   = '0;
        exp_valid = 1'b0;
        exp_last  = 1'b0;
        exp_busy  = 1'b0;
        exp_data  = '0;
        exp_owner = -1;
        exp_beats = 1;
        if (rst_n) begin
            if (m_locked) begin
                exp_owner = m_owner;
                exp_valid = valid_i[m_owner];
                exp_last  = (m_rem == 1);
                exp_busy  = 1'b1;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int j = (m_last + k) % N;
                    if (exp_owner < 0 && valid_i[j]) exp_owner = j;
                end
            end
            if (exp_owner >= 0) begin
                exp_sel[exp_owner] = 1'b1;
                exp_data = data_i[exp_owner*DATA_W +: DATA_W];
                if (!m_locked) begin
                    exp_valid = 1'b1;
                    exp_beats = beats_of(exp_owner);
                    exp_last  = (exp_beats == 1);
                end
            end
        end
        exp_ready = exp_sel & {N{ready_i}};
        exp_fire  = exp_valid && ready_i;
    endtask

    task automatic model_commit();
        if (!rst_n) begin
            model_reset();
        end else if (exp_fire) begin
            $display("[TB] beat src=%0d last=%0b", exp_owner, exp_last);
            if (m_locked) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_locked = 0;
                    m_last   = m_owner;
                end
            end else if (exp_beats == 1) begin
                m_last = exp_owner;
            end else begin
                m_locked = 1;
                m_owner  = exp_owner;
                m_rem    = exp_beats - 1;
            end
        end
    endtask

    task automatic rand_data();
        for (int j = 0; j < N; j++)
            data_i[j*DATA_W +: DATA_W] = DATA_W'({$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic set_size(int j, int sz);
        size_i[j*SIZE_W +: SIZE_W] = SIZE_W'(sz);
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic test_reset();
        valid_i    = '1;
        has_data_i = '1;
        size_i     = '1;
        ready_i    = 1'b1;
        rand_data();
        settle();
        tests_run++;
        if ({sel_o, ready_o, valid_o, last_o, busy_o} !== '0 || data_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: sel=%b rdy=%b v=%b last=%b busy=%b data=%h, want all zero",
                     sel_o, ready_o, valid_o, last_o, busy_o, data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want [5];
        want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        valid_i    = '1;
        has_data_i = '0;
        ready_i    = 1'b1;
        for (int c = 0; c < 5; c++) begin
            rand_data();
            size_i = SIZE_W*N'($urandom);
            settle();
            tests_run++;
            if ({sel_o, ready_o, valid_o, last_o, busy_o} !== {exp_sel, exp_ready, exp_valid, exp_last, exp_busy}
                || data_o !== exp_data || sel_o !== want[c] || last_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL round_robin c%0d: sel=%b last=%b data=%h, want sel=%b last=1 data=%h",
                         c, sel_o, last_o, data_o, want[c], exp_data);
            end
            advance();
        end
    endtask

    task automatic test_burst_lock();
        valid_i    = 4'b0111;
        has_data_i = 4'b0010;
        size_i     = '0;
        set_size(1, 5);
        ready_i    = 1'b1;
        for (int c = 0; c < 5; c++) begin
            logic [N-1:0] want_sel;
            want_sel = (c < 4) ? 4'b0010 : 4'b0100;
            rand_data();
            settle();
            tests_run++;
            if ({sel_o, ready_o, valid_o, last_o, busy_o} !== {exp_sel, exp_ready, exp_valid, exp_last, exp_busy}
                || data_o !== exp_data || sel_o !== want_sel || (c < 4 && last_o !== (c == 3))) begin
                tests_failed++;
                $display("FAIL burst_lock c%0d: sel=%b rdy=%b last=%b busy=%b, want sel=%b rdy=%b last=%b busy=%b",
                         c, sel_o, ready_o, last_o, busy_o, want_sel, exp_ready, exp_last, exp_busy);
            end
            advance();
        end
    endtask

    task automatic test_stall();
        int fires;
        int c;
        valid_i    = 4'b1000;
        has_data_i = 4'b1000;
        size_i     = '0;
        set_size(3, 5);
        ready_i    = 1'b1;
        rand_data();
        settle();
        tests_run++;
        if (sel_o !== 4'b1000 || valid_o !== 1'b1 || last_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_start: sel=%b v=%b last=%b, want sel=1000 v=1 last=0", sel_o, valid_o, last_o);
        end
        fires = exp_fire ? 1 : 0;
        advance();
        c = 1;
        while (m_locked && c < 20) begin
            ready_i = (c % 2 == 0);
            valid_i = N'($urandom_range(0, 7)) | ((c == 3 || c == 4) ? 4'b0000 : 4'b1000);
            size_i  = SIZE_W*N'($urandom);
            rand_data();
            settle();
            tests_run++;
            if ({sel_o, ready_o, valid_o, last_o, busy_o} !== {exp_sel, exp_ready, exp_valid, exp_last, exp_busy}
                || data_o !== exp_data || (ready_o & 4'b0111) !== 4'b0000) begin
                tests_failed++;
                $display("FAIL stall c%0d: sel=%b rdy=%b v=%b last=%b busy=%b, want sel=%b rdy=%b v=%b last=%b busy=%b",
                         c, sel_o, ready_o, valid_o, last_o, busy_o, exp_sel, exp_ready, exp_valid, exp_last, exp_busy);
            end
            if (exp_fire) fires++;
            advance();
            c++;
        end
        valid_i = '0;
        settle();
        tests_run++;
        if (fires !== 4 || c >= 20 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_done: fires=%0d cycles=%0d busy=%b, want fires=4 busy=0", fires, c, busy_o);
        end
    endtask

    task automatic test_no_data_size();
        valid_i    = 4'b0001;
        has_data_i = 4'b0000;
        size_i     = '0;
        set_size(0, 6);
        ready_i    = 1'b1;
        rand_data();
        settle();
        tests_run++;
        if (last_o !== 1'b1 || busy_o !== 1'b0 || sel_o !== 4'b0001 || data_o !== exp_data) begin
            tests_failed++;
            $display("FAIL no_data_size: last=%b busy=%b sel=%b, want last=1 busy=0 sel=0001", last_o, busy_o, sel_o);
        end
        advance();
        valid_i = '0;
        settle();
        tests_run++;
        if ({sel_o, ready_o, valid_o, last_o, busy_o} !== '0 || data_o !== '0) begin
            tests_failed++;
            $display("FAIL idle_empty: sel=%b rdy=%b v=%b last=%b busy=%b data=%h, want all zero",
                     sel_o, ready_o, valid_o, last_o, busy_o, data_o);
        end
    endtask

    task automatic test_reset_mid_burst();
        valid_i    = 4'b0100;
        has_data_i = 4'b0100;
        size_i     = '0;
        set_size(2, 5);
        ready_i    = 1'b1;
        for (int c = 0; c < 2; c++) begin
            rand_data();
            settle();
            tests_run++;
            if ({sel_o, ready_o, valid_o, last_o, busy_o} !== {exp_sel, exp_ready, exp_valid, exp_last, exp_busy}
                || data_o !== exp_data) begin
                tests_failed++;
                $display("FAIL mid_burst_pre c%0d: sel=%b v=%b last=%b busy=%b, want sel=%b v=%b last=%b busy=%b",
                         c, sel_o, valid_o, last_o, busy_o, exp_sel, exp_valid, exp_last, exp_busy);
            end
            if (c == 0) advance();
        end
        rst_n = 1'b0;
        settle();
        tests_run++;
        if ({sel_o, ready_o, valid_o, last_o, busy_o} !== '0 || data_o !== '0) begin
            tests_failed++;
            $display("FAIL mid_burst_reset: sel=%b rdy=%b v=%b last=%b busy=%b, want all zero",
                     sel_o, ready_o, valid_o, last_o, busy_o);
        end
        model_reset();
        advance();
        rst_n      = 1'b1;
        valid_i    = 4'b0101;
        has_data_i = 4'b0000;
        settle();
        tests_run++;
        if (sel_o !== 4'b0001 || busy_o !== 1'b0 || sel_o !== exp_sel || data_o !== exp_data) begin
            tests_failed++;
            $display("FAIL post_reset_grant: sel=%b busy=%b, want sel=0001 busy=0", sel_o, busy_o);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        logic want_last [4];
        want_last  = '{1'b0, 1'b1, 1'b0, 1'b1};
        valid_i    = 4'b0001;
        has_data_i = 4'b0001;
        size_i     = '0;
        set_size(0, 4);
        ready_i    = 1'b1;
        for (int c = 0; c < 4; c++) begin
            rand_data();
            settle();
            tests_run++;
            if (valid_o !== 1'b1 || last_o !== want_last[c] || sel_o !== 4'b0001 || data_o !== exp_data) begin
                tests_failed++;
                $display("FAIL back_to_back c%0d: v=%b last=%b sel=%b, want v=1 last=%b sel=0001",
                         c, valid_o, last_o, sel_o, want_last[c]);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            valid_i    = N'($urandom);
            has_data_i = N'($urandom);
            size_i     = SIZE_W*N'($urandom);
            ready_i    = ($urandom_range(0, 3) != 0);
            rand_data();
            settle();
            tests_run++;
            if ({sel_o, ready_o, valid_o, last_o, busy_o} !== {exp_sel, exp_ready, exp_valid, exp_last, exp_busy}
                || data_o !== exp_data) begin
                tests_failed++;
                $display("FAIL random c%0d: sel=%b rdy=%b v=%b last=%b busy=%b, want sel=%b rdy=%b v=%b last=%b busy=%b",
                         c, sel_o, ready_o, valid_o, last_o, busy_o, exp_sel, exp_ready, exp_valid, exp_last, exp_busy);
            end
            advance();
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        valid_i    = '0;
        data_i     = '0;
        size_i     = '0;
        has_data_i = '0;
        ready_i    = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_burst_lock();
        test_stall();
        test_no_data_size();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
